// File: rtl/adder_arb_pkg.sv
// Shared types, default parameters and the overflow-aware add helper for adder_arbiter.
// Saturation on overflow is enabled by defining ADDER_ARB_SAT_EN.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 32;
    localparam int DEF_LAT   = 2;
    localparam int MAX_W     = 64;
    localparam int MSB_W     = $clog2(MAX_W);

    // Operands arrive sign-extended to MAX_W; msb is the sign bit position of the real width.
    // Returns {ovf, sum} where sum is valid in its low msb+1 bits.
    function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [MSB_W-1:0] msb);
        logic [MAX_W-1:0] sum;
        logic             ovf;
`ifdef ADDER_ARB_SAT_EN
        logic [MAX_W-1:0] max_v;
`endif
        sum = a + b;
        ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
`ifdef ADDER_ARB_SAT_EN
        max_v = (MAX_W'(1) << msb) - MAX_W'(1);
        if (ovf) begin
            sum = a[msb] ? ~max_v : max_v;
        end
`endif
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_REQ-1.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(N_REQ);

    int          c;
    logic [IW-1:0] ci;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        ci  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            ci = IW'(c);
            if (!any && req[ci]) begin
                any     = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Time-multiplexes one signed adder between N_REQ round-robin requesters.
// Define ADDER_ARB_SAT_EN to clamp o_sum on overflow instead of wrapping.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int LAT   = DEF_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0][W-1:0]   i_a,
    input  logic [N_REQ-1:0][W-1:0]   i_b,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_valid,
    output logic [$clog2(N_REQ)-1:0]  o_id,
    output logic [W-1:0]              o_sum,
    output logic                      o_ovf
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e              state, state_d;
    logic [IW-1:0]       ptr;
    logic [CW-1:0]       cnt;
    logic                arb_en;
    logic                fin;

    logic [N_REQ-1:0]    win_gnt;
    logic [IW-1:0]       win_idx;
    logic                win_any;

    logic signed [W-1:0] a_q, b_q;
    logic [IW-1:0]       id_q;
    logic [MAX_W:0]      add_res;
    logic                unused_res;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (i_req),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        arb_en  = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_d = BUSY;
                    arb_en  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_d = DONE;
                    fin     = 1'b1;
                end
            end
            DONE: begin
                if (win_any) begin
                    state_d = BUSY;
                    arb_en  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt   <= '0;
            o_valid <= 1'b0;
            o_id    <= '0;
            o_sum   <= '0;
            o_ovf   <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            o_gnt   <= '0;
            o_valid <= fin;
            if (arb_en) begin
                o_gnt <= win_gnt;
                ptr   <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                cnt   <= CW'(LAT - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (fin) begin
                o_sum <= add_res[W-1:0];
                o_ovf <= add_res[MAX_W];
                o_id  <= id_q;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are only read after a grant has loaded them.
    always_ff @(posedge i_clk) begin
        if (arb_en) begin
            a_q  <= i_a[win_idx];
            b_q  <= i_b[win_idx];
            id_q <= win_idx;
        end
    end

    assign add_res    = sat_add(MAX_W'(a_q), MAX_W'(b_q), MSB_W'(W - 1));
    assign unused_res = ^add_res;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed cases plus random request batches against a
// transaction-level round-robin / arithmetic model. Honours ADDER_ARB_SAT_EN for expectations.
module tb_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int IW  = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] a_in, b_in;
    logic [N-1:0]        gnt;
    logic                valid;
    logic [IW-1:0]       id;
    logic [W-1:0]        sum;
    logic                ovf;

    int checks = 0;
    int errors = 0;

    int            model_ptr = 0;
    logic [IW-1:0] last_id   = '0;
    logic [W-1:0]  last_sum  = '0;
    logic          last_ovf  = 1'b0;

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_a     (a_in),
        .i_b     (b_in),
        .o_gnt   (gnt),
        .o_valid (valid),
        .o_id    (id),
        .o_sum   (sum),
        .o_ovf   (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: exact signed sum, then wrap or clamp into W bits.
    task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] s, output logic o);
        longint sa, sb, full, maxp, minn;
        sa   = longint'(signed'(a));
        sb   = longint'(signed'(b));
        full = sa + sb;
        maxp = (longint'(1) << (W - 1)) - 1;
        minn = -(longint'(1) << (W - 1));
        o    = (full > maxp) || (full < minn);
        s    = full[W-1:0];
`ifdef ADDER_ARB_SAT_EN
        if (o) s = (full > 0) ? maxp[W-1:0] : minn[W-1:0];
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'(0));
        check({tag, "_valid"}, 64'(valid), 64'(0));
        check({tag, "_id"}, 64'(id), 64'(0));
        check({tag, "_sum"}, 64'(sum), 64'(0));
        check({tag, "_ovf"}, 64'(ovf), 64'(0));
    endtask

    // Raise all requests in mask at once; expect round-robin grants spaced LAT+1 cycles apart
    // and each result LAT cycles after its grant. Held outputs are checked on every cycle.
    task automatic run_batch(input string tag, input logic [N-1:0] mask,
                             input logic [N-1:0][W-1:0] av, input logic [N-1:0][W-1:0] bv);
        int           order[$];
        logic [N-1:0] rem;
        logic [N-1:0] exp_g;
        logic         exp_v;
        int           p, n, k;
        logic [W-1:0] s;
        logic         o;
        rem = mask;
        p   = model_ptr;
        while (rem != '0) begin
            for (int i = 0; i < N; i++) begin
                k = (p + i) % N;
                if (rem[k]) begin
                    order.push_back(k);
                    rem[k] = 1'b0;
                    p = (k + 1) % N;
                    break;
                end
            end
        end
        model_ptr = p;
        n    = order.size();
        a_in = av;
        b_in = bv;
        req  = mask;
        for (int cyc = 1; cyc <= n * (LAT + 1); cyc++) begin
            tick();
            exp_g = '0;
            exp_v = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (cyc == 1 + j * (LAT + 1)) exp_g[order[j]] = 1'b1;
                if (cyc == 1 + j * (LAT + 1) + LAT) begin
                    exp_v = 1'b1;
                    ref_add(av[order[j]], bv[order[j]], s, o);
                    last_sum = s;
                    last_ovf = o;
                    last_id  = IW'(order[j]);
                end
            end
            check({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
            check({tag, "_valid"}, 64'(valid), 64'(exp_v));
            check({tag, "_id"}, 64'(id), 64'(last_id));
            check({tag, "_sum"}, 64'(sum), 64'(last_sum));
            check({tag, "_ovf"}, 64'(ovf), 64'(last_ovf));
            req = req & ~gnt;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return W'($urandom());
        endcase
    endfunction

    logic [N-1:0][W-1:0] av, bv;

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;

        // All four at once, a = id, b = 10: order 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            av[i] = W'(i);
            bv[i] = W'(10);
        end
        run_batch("all4", 4'b1111, av, bv);

        // Single request 3 + 4.
        av = '0; bv = '0;
        av[0] = 32'd3; bv[0] = 32'd4;
        run_batch("single", 4'b0001, av, bv);

        // Pointer moves past req1, then req3 must beat req0.
        av[1] = 32'd20; bv[1] = 32'd22;
        run_batch("ptr_set", 4'b0010, av, bv);
        av[0] = 32'd100; bv[0] = 32'd1;
        av[3] = 32'd300; bv[3] = 32'd3;
        run_batch("wrap", 4'b1001, av, bv);

        // Overflow and negative operand corners.
        av[2] = 32'h7FFF_FFFF; bv[2] = 32'd1;
        run_batch("pos_ovf", 4'b0100, av, bv);
        av[3] = -32'sd5; bv[3] = -32'sd7;
        run_batch("neg_sum", 4'b1000, av, bv);
        av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
        run_batch("neg_ovf", 4'b0010, av, bv);

        // Reset while BUSY: no result, outputs cleared, pointer back to 0.
        a_in[1] = 32'd5; b_in[1] = 32'd6;
        req = 4'b0010;
        tick();
        check("rst_op_gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        tick();
        check("rst_op_busy", 64'(valid), 64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("mid_reset");
        model_ptr = 0;
        last_id   = '0;
        last_sum  = '0;
        last_ovf  = 1'b0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("post_rst_valid", 64'(valid), 64'(0));
            check("post_rst_gnt", 64'(gnt), 64'(0));
        end
        av[0] = 32'd1; bv[0] = 32'd2;
        av[3] = 32'd30; bv[3] = 32'd40;
        run_batch("post_rst_pair", 4'b1001, av, bv);
        av[2] = 32'd9; bv[2] = 32'd8;
        run_batch("post_rst_req2", 4'b0100, av, bv);

        // Random batches of simultaneous requests with corner-biased operands.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                av[i] = rand_operand();
                bv[i] = rand_operand();
            end
            run_batch("rand", N'($urandom_range(1, (1 << N) - 1)), av, bv);
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
